// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
// Stage count derives from the operand width and the segment width.
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int calc_stages(input int width, input int seg_w);
    return width / seg_w;
  endfunction

endpackage

// File: rtl/rca_segment.sv
// Combinational ripple-carry adder for one SEG_W-bit segment.
// c_msb_in is the carry into the segment's top bit and is used for overflow detection.
module rca_segment #(
  parameter int SEG_W = 4
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             ci,
  output logic [SEG_W-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic carry;

  always_comb begin
    carry    = ci;
    s        = '0;
    c_msb_in = ci;
    for (int i = 0; i < SEG_W; i++) begin
      if (i == SEG_W - 1) c_msb_in = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG_W-bit segment resolved per stage,
// global stall on output backpressure, and an internal reset-release synchronizer.
module pipelined_rca_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calc_stages(WIDTH, SEG_W);
  localparam int LAST   = STAGES - 1;

  if ((SEG_W < 1) || (WIDTH % SEG_W != 0)) begin : g_param_check
    $error("pipelined_rca_adder: WIDTH must be a non-zero multiple of SEG_W");
  end

  logic [1:0]       sync_q;
  logic             rst_sync_n;
  logic             stall;
  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  // Assertion is immediate through rst_n; release reaches the pipeline two edges later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= {sync_q[0], 1'b1};
  end
  assign rst_sync_n = sync_q[1];

  assign stall    = out_valid & ~out_ready;
  assign en       = ~stall;
  assign in_ready = ~stall;

  assign b_eff = b ^ {WIDTH{sub}};
  assign c0    = (sub == OP_SUB) ? 1'b1 : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG_W;
    localparam int HI = LO + SEG_W - 1;

    logic [SEG_W-1:0] sa;
    logic [SEG_W-1:0] sb;
    logic [SEG_W-1:0] ss;
    logic             sci;
    logic             sco;
    logic             v_d;
    logic [HI:0]      s_d;
    logic             v_q;
    logic             c_q;
    logic [HI:0]      s_q;

    if (k == 0) begin : g_in
      assign sa  = a[SEG_W-1:0];
      assign sb  = b_eff[SEG_W-1:0];
      assign sci = c0;
      assign v_d = in_valid;
      assign s_d = ss;
    end else begin : g_in
      assign sa  = g_stage[k-1].g_fwd.ra_q[HI:LO];
      assign sb  = g_stage[k-1].g_fwd.rb_q[HI:LO];
      assign sci = g_stage[k-1].c_q;
      assign v_d = g_stage[k-1].v_q;
      assign s_d = {ss, g_stage[k-1].s_q};
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
      if (!rst_sync_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_d;
        c_q <= sco;
        s_q <= s_d;
      end
    end

    if (k < LAST) begin : g_fwd
      // Operand bits not yet consumed travel alongside the partial sum.
      logic             c_msb_unused;
      logic [WIDTH-1:HI+1] ra_d;
      logic [WIDTH-1:HI+1] rb_d;
      logic [WIDTH-1:HI+1] ra_q;
      logic [WIDTH-1:HI+1] rb_q;

      rca_segment #(.SEG_W(SEG_W)) u_seg (
        .a        (sa),
        .b        (sb),
        .ci       (sci),
        .s        (ss),
        .co       (sco),
        .c_msb_in (c_msb_unused)
      );

      if (k == 0) begin : g_src
        assign ra_d = a[WIDTH-1:HI+1];
        assign rb_d = b_eff[WIDTH-1:HI+1];
      end else begin : g_src
        assign ra_d = g_stage[k-1].g_fwd.ra_q[WIDTH-1:HI+1];
        assign rb_d = g_stage[k-1].g_fwd.rb_q[WIDTH-1:HI+1];
      end

      always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
          ra_q <= '0;
          rb_q <= '0;
        end else if (en) begin
          ra_q <= ra_d;
          rb_q <= rb_d;
        end
      end
    end else begin : g_last
      logic c_msb;
      logic cm_q;

      rca_segment #(.SEG_W(SEG_W)) u_seg (
        .a        (sa),
        .b        (sb),
        .ci       (sci),
        .s        (ss),
        .co       (sco),
        .c_msb_in (c_msb)
      );

      always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n)  cm_q <= 1'b0;
        else if (en)      cm_q <= c_msb;
      end
    end
  end

  assign out_valid = g_stage[LAST].v_q;
  assign sum       = g_stage[LAST].s_q;
  assign cout      = g_stage[LAST].c_q;
  assign ovf       = g_stage[LAST].c_q ^ g_stage[LAST].g_last.cm_q;

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench for pipelined_rca_adder: directed cases, backpressure, mid-flight reset
// and randomized traffic against an arithmetic reference model with an in-order queue.
module tb_pipelined_rca_adder;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int res_cyc  = 0;
  int n_out    = 0;
  logic        got_result   = 1'b0;
  logic [17:0] res_vec      = '0;
  logic        hold_pending = 1'b0;
  logic [18:0] hold_vec     = '0;
  logic [17:0] exp_q[$];

  pipelined_rca_adder #(.WIDTH(16), .SEG_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [17:0] ref_op(input logic [15:0] ra, input logic [15:0] rb,
                                         input logic rcin, input logic rsub);
    int u;
    int s;
    int sa;
    int sb;
    logic c;
    logic o;
    sa = int'($signed(ra));
    sb = int'($signed(rb));
    if (rsub) begin
      u = int'(ra) - int'(rb);
      s = sa - sb;
      c = (ra >= rb);
    end else begin
      u = int'(ra) + int'(rb) + int'(rcin);
      s = sa + sb + int'(rcin);
      c = (u > 65535);
    end
    o = (s > 32767) || (s < -32768);
    return {o, c, u[15:0]};
  endfunction

  task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                      input logic icin, input logic isub, input logic ior);
    logic [17:0] e;
    @(negedge clk);
    in_valid  = iv;
    a         = ia;
    b         = ib;
    cin       = icin;
    sub       = isub;
    out_ready = ior;
    cyc++;
    #4;
    chk("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
    if (hold_pending) chk("stall_hold", 32'({out_valid, ovf, cout, sum}), 32'(hold_vec));
    if (exp_q.size() == 0) begin
      chk("spurious_valid", 32'(out_valid), 32'd0);
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      chk("result", 32'({ovf, cout, sum}), 32'(e));
      got_result = 1'b1;
      res_cyc    = cyc;
      res_vec    = {ovf, cout, sum};
      n_out++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(ref_op(a, b, cin, sub));
      acc_cyc = cyc;
    end
    hold_pending = out_valid && !out_ready;
    hold_vec     = {out_valid, ovf, cout, sum};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic directed(input string tag, input logic [15:0] da, input logic [15:0] db,
                          input logic dcin, input logic dsub, input logic [17:0] exp);
    int n;
    got_result = 1'b0;
    step(1'b1, da, db, dcin, dsub, 1'b1);
    n = 0;
    while (!got_result && n < 20) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk({tag, "_done"}, 32'(got_result), 32'd1);
    chk({tag, "_value"}, 32'(res_vec), 32'(exp));
    chk({tag, "_latency"}, 32'(res_cyc - acc_cyc - 1), 32'd3);
  endtask

  initial begin
    int sent;
    int low_cnt;
    int out0;
    int n;
    logic iv;
    logic orr;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_outputs", 32'({ovf, cout, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(4);

    directed("add",      16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555);
    directed("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000);
    directed("sovf",     16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000);
    directed("sub_neg",  16'h0005, 16'h0007, 1'b0, 1'b1, 18'h0FFFE);
    directed("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 18'h37FFF);
    directed("add_cin",  16'h00FF, 16'h0000, 1'b1, 1'b0, 18'h00100);
    directed("sub_cin",  16'h0010, 16'h0010, 1'b1, 1'b1, 18'h10000);

    // Backpressure: 8 back-to-back adds with out_ready low for 3 cycles mid-stream.
    sent    = 0;
    low_cnt = 0;
    out0    = n_out;
    for (int i = 0; i < 30 && (sent < 8 || exp_q.size() > 0); i++) begin
      orr = !(i >= 5 && i <= 7);
      iv  = (sent < 8);
      step(iv, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0, orr);
      if (iv && in_ready) sent++;
      if (!in_ready) low_cnt++;
    end
    chk("bp_results", 32'(n_out - out0), 32'd8);
    chk("bp_in_ready_low", 32'(low_cnt), 32'd3);

    // Mid-flight reset: three ops in flight, first result held by backpressure.
    for (int i = 0; i < 3; i++) step(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!out_valid && n < 10) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("pre_reset_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_outputs", 32'({ovf, cout, sum}), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    hold_pending = 1'b0;
    idle(6);
    directed("post_reset", 16'hABCD, 16'h1111, 1'b0, 1'b1, 18'h19ABC);

    // Random traffic with random backpressure.
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 3) != 0), 16'($urandom), 16'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom_range(0, 3) != 0));
    end
    n = 0;
    while (exp_q.size() > 0 && n < 50) begin
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
